// File: rtl/tile_fetch.sv
// Tile fetch: downscaled, scrolled raster -> tile-map read -> tile index + sprite ROM address; 2 pix_en ticks latency, holds while pix_en low.
// Optional horizontal flip via map_data bit 4 when TILE_FLIP_EN is defined.
module tile_fetch #(
  parameter int SCR_W     = 320,
  parameter int SCR_H     = 240,
  parameter int MAP_COLS  = 20,
  parameter int MAP_DEPTH = 300
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pix_en,
  input  logic [9:0]                   h_cnt,
  input  logic [9:0]                   v_cnt,
  input  logic [9:0]                   scroll_h,
  input  logic [9:0]                   scroll_v,
  output logic [$clog2(MAP_DEPTH)-1:0] map_addr,
`ifdef TILE_FLIP_EN
  input  logic [4:0]                   map_data,
`else
  input  logic [3:0]                   map_data,
`endif
  output logic [7:0]                   rom_addr,
  output logic [3:0]                   now_pixel_idx,
  output logic [9:0]                   h_cnt_d,
  output logic [9:0]                   v_cnt_d,
  output logic [9:0]                   pos_h,
  output logic [9:0]                   pos_v,
  output logic                         active_d
);

  localparam int AW = $clog2(MAP_DEPTH);

  logic       frame_start;
  logic [9:0] eff_h, eff_v;
  logic [9:0] sum_x, sum_y;
  logic [9:0] x, y;
  logic       active;
  logic [3:0] col;

  logic [3:0] x_s0, y_s0;
  logic [9:0] h_s0, v_s0;
  logic       act_s0;

  // The frame-start pixel already uses the freshly latched scroll.
  always_comb begin
    frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    eff_h = pos_h;
    eff_v = pos_v;
    if (frame_start) begin
      eff_h = (scroll_h >= 10'(SCR_W)) ? 10'd0 : scroll_h;
      eff_v = (scroll_v >= 10'(SCR_H)) ? 10'd0 : scroll_v;
    end
    sum_x  = {1'b0, h_cnt[9:1]} + eff_h;
    sum_y  = {1'b0, v_cnt[9:1]} + eff_v;
    x      = (sum_x >= 10'(SCR_W)) ? sum_x - 10'(SCR_W) : sum_x;
    y      = (sum_y >= 10'(SCR_H)) ? sum_y - 10'(SCR_H) : sum_y;
    active = (h_cnt < 10'(2 * SCR_W)) && (v_cnt < 10'(2 * SCR_H));
  end

  always_comb begin
`ifdef TILE_FLIP_EN
    col = map_data[4] ? ~x_s0 : x_s0;
`else
    col = x_s0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_h <= '0;
      pos_v <= '0;
    end else if (pix_en && frame_start) begin
      pos_h <= eff_h;
      pos_v <= eff_v;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_addr <= '0;
      x_s0     <= '0;
      y_s0     <= '0;
      h_s0     <= '0;
      v_s0     <= '0;
      act_s0   <= 1'b0;
    end else if (pix_en) begin
      map_addr <= AW'(32'(y[9:4]) * MAP_COLS + 32'(x[9:4]));
      x_s0     <= x[3:0];
      y_s0     <= y[3:0];
      h_s0     <= h_cnt;
      v_s0     <= v_cnt;
      act_s0   <= active;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now_pixel_idx <= '0;
      rom_addr      <= '0;
      h_cnt_d       <= '0;
      v_cnt_d       <= '0;
      active_d      <= 1'b0;
    end else if (pix_en) begin
      now_pixel_idx <= act_s0 ? map_data[3:0] : 4'd0;
      rom_addr      <= act_s0 ? {y_s0, col} : 8'd0;
      h_cnt_d       <= h_s0;
      v_cnt_d       <= v_s0;
      active_d      <= act_s0;
    end
  end

endmodule

// File: tb/tb_tile_fetch.sv
// Bench for tile_fetch: directed literal cases plus randomized raster/scroll traffic against a behavioural model.
module tb_tile_fetch;

`ifdef TILE_FLIP_EN
  localparam int MDW = 5;
`else
  localparam int MDW = 4;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           pix_en;
  logic [9:0]     h_cnt, v_cnt, scroll_h, scroll_v;
  logic [8:0]     map_addr;
  logic [MDW-1:0] map_data;
  logic [7:0]     rom_addr;
  logic [3:0]     now_pixel_idx;
  logic [9:0]     h_cnt_d, v_cnt_d, pos_h, pos_v;
  logic           active_d;

  int checks = 0;
  int errors = 0;

  logic [MDW-1:0] mem [512];

  tile_fetch dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .scroll_h(scroll_h), .scroll_v(scroll_v),
    .map_addr(map_addr), .map_data(map_data),
    .rom_addr(rom_addr), .now_pixel_idx(now_pixel_idx),
    .h_cnt_d(h_cnt_d), .v_cnt_d(v_cnt_d),
    .pos_h(pos_h), .pos_v(pos_v), .active_d(active_d)
  );

  always #5 clk = ~clk;

  // Tile-map BRAM: registered read, one clock after the address.
  always @(posedge clk) map_data <= mem[map_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per pix_en tick, inputs -> wrapped coords -> fetch; outputs reflect the tick before last.
  int m_pos_h, m_pos_v, m_addr, m_x0, m_y0, m_h0, m_v0, m_act0;
  int m_idx, m_rom, m_hd, m_vd, m_act;
  int mx, my, md, mcol;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos_h = 0; m_pos_v = 0; m_addr = 0;
      m_x0 = 0; m_y0 = 0; m_h0 = 0; m_v0 = 0; m_act0 = 0;
      m_idx = 0; m_rom = 0; m_hd = 0; m_vd = 0; m_act = 0;
    end else if (pix_en) begin
      if (m_act0 != 0) begin
        md    = int'(mem[m_addr]);
        m_idx = md % 16;
        mcol  = m_x0 % 16;
        if (MDW == 5 && md >= 16) mcol = 15 - mcol;
        m_rom = (m_y0 % 16) * 16 + mcol;
      end else begin
        m_idx = 0;
        m_rom = 0;
      end
      m_hd  = m_h0;
      m_vd  = m_v0;
      m_act = m_act0;
      if (h_cnt == 0 && v_cnt == 0) begin
        m_pos_h = (scroll_h < 320) ? int'(scroll_h) : 0;
        m_pos_v = (scroll_v < 240) ? int'(scroll_v) : 0;
      end
      mx = int'(h_cnt) / 2 + m_pos_h;
      if (mx >= 320) mx = mx - 320;
      my = int'(v_cnt) / 2 + m_pos_v;
      if (my >= 240) my = my - 240;
      m_addr = (my / 16) * 20 + mx / 16;
      m_x0   = mx;
      m_y0   = my;
      m_h0   = int'(h_cnt);
      m_v0   = int'(v_cnt);
      m_act0 = (h_cnt < 640 && v_cnt < 480) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    chk("map_addr", 32'(map_addr), m_addr);
    chk("now_pixel_idx", 32'(now_pixel_idx), m_idx);
    chk("rom_addr", 32'(rom_addr), m_rom);
    chk("h_cnt_d", 32'(h_cnt_d), m_hd);
    chk("v_cnt_d", 32'(v_cnt_d), m_vd);
    chk("pos_h", 32'(pos_h), m_pos_h);
    chk("pos_v", 32'(pos_v), m_pos_v);
    chk("active_d", 32'(active_d), m_act);
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One pix_en pulse, followed by one idle clock so the BRAM data settles.
  task automatic tick(input int h, input int v);
    h_cnt  = 10'(h);
    v_cnt  = 10'(v);
    pix_en = 1'b1;
    idle(1);
    pix_en = 1'b0;
    idle(1);
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0;
    h_cnt = '0; v_cnt = '0; scroll_h = '0; scroll_v = '0;
    for (int i = 0; i < 512; i++) mem[i] = MDW'($urandom);
`ifdef TILE_FLIP_EN
    mem[21] = 5'h12;
`else
    mem[21] = 4'd7;
`endif
    mem[0] = MDW'(5);
    mem[1] = MDW'(3);
    idle(3);
    chk("reset_idx", 32'(now_pixel_idx), 0);
    chk("reset_active_d", 32'(active_d), 0);
    rst = 1'b0;
    idle(1);

    // Basic fetch
    tick(0, 0);
    tick(34, 50);
    chk("basic_map_addr", 32'(map_addr), 21);
    tick(36, 50);
`ifdef TILE_FLIP_EN
    chk("flip_idx", 32'(now_pixel_idx), 2);
    chk("flip_rom", 32'(rom_addr), 158);
`else
    chk("basic_idx", 32'(now_pixel_idx), 7);
    chk("basic_rom", 32'(rom_addr), 145);
`endif
    chk("basic_h_cnt_d", 32'(h_cnt_d), 34);
    chk("basic_v_cnt_d", 32'(v_cnt_d), 50);
    chk("basic_active_d", 32'(active_d), 1);

    // Wrap
    scroll_h = 10'd310; scroll_v = 10'd230;
    tick(0, 0);
    chk("wrap_pos_h", 32'(pos_h), 310);
    chk("wrap_pos_v", 32'(pos_v), 230);
    tick(40, 40);
    chk("wrap_map_addr", 32'(map_addr), 0);
    tick(42, 40);
    chk("wrap_rom", 32'(rom_addr), 170);

    // Scroll latch only at frame start
    scroll_h = 10'd0; scroll_v = 10'd0;
    tick(0, 0);
    scroll_h = 10'd16;
    tick(0, 100);
    chk("latch_hold_pos_h", 32'(pos_h), 0);
    tick(0, 0);
    chk("latch_pos_h", 32'(pos_h), 16);
    chk("latch_map_addr", 32'(map_addr), 1);
    tick(2, 0);
    chk("latch_idx", 32'(now_pixel_idx), 3);
    scroll_h = 10'd400;
    tick(0, 0);
    chk("illegal_scroll_pos_h", 32'(pos_h), 0);
    scroll_h = 10'd0;

    // Blanking then hold
    tick(700, 10);
    tick(0, 12);
    chk("blank_active_d", 32'(active_d), 0);
    chk("blank_idx", 32'(now_pixel_idx), 0);
    chk("blank_rom", 32'(rom_addr), 0);
    chk("blank_h_cnt_d", 32'(h_cnt_d), 700);
    h_cnt = 10'd34; v_cnt = 10'd50;
    idle(5);
    chk("hold_h_cnt_d", 32'(h_cnt_d), 700);
    chk("hold_v_cnt_d", 32'(v_cnt_d), 10);
    chk("hold_map_addr", 32'(map_addr), 0);

    // Mid-line reset while pix_en toggles
    tick(100, 20);
    tick(102, 20);
    chk("pre_reset_active_d", 32'(active_d), 1);
    pix_en = 1'b1;
    rst = 1'b1;
    #1;
    chk("midreset_h_cnt_d", 32'(h_cnt_d), 0);
    chk("midreset_active_d", 32'(active_d), 0);
    chk("midreset_map_addr", 32'(map_addr), 0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      pix_en = ~pix_en;
    end
    pix_en = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(1);
    tick(100, 20);
    chk("post_reset_tick1_active_d", 32'(active_d), 0);
    tick(102, 20);
    chk("post_reset_tick2_active_d", 32'(active_d), 1);
    chk("post_reset_tick2_h_cnt_d", 32'(h_cnt_d), 100);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      scroll_h = 10'($urandom_range(0, 511));
      scroll_v = 10'($urandom_range(0, 511));
      if ($urandom_range(0, 9) == 0) tick(0, 0);
      else tick(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
      idle(int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
